// File: rtl/memport_bridge_pkg.sv
// Shared definitions for the CGRA memory-port bridge: FSM encoding and
// request-queue entry layout {write_rq, addr, wdata}.
package memport_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } state_e;

  localparam int unsigned WE_FIELD_W = 1;

  function automatic int unsigned entry_width(input int unsigned addr_w,
                                              input int unsigned data_w);
    return WE_FIELD_W + addr_w + data_w;
  endfunction

endpackage

// File: rtl/memport_req_fifo.sv
// Request queue for the memory-port bridge: power-of-two depth, wrapping
// pointers, occupancy counter one bit wider than the pointers.
module memport_req_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/memory_port_bridge_32b.sv
// Bridges a CGRA memory port onto a req/gnt/rvalid backing memory, queueing
// requests and keeping at most one read outstanding.
module memory_port_bridge_32b
  import memport_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  port_valid,
  output logic                  port_ready,
  input  logic                  port_write_rq,
  input  logic [ADDR_WIDTH-1:0] port_addr,
  input  logic [DATA_WIDTH-1:0] port_to_mem,
  output logic [DATA_WIDTH-1:0] port_from_mem,
  output logic                  port_rvalid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned ENTRY_W = entry_width(ADDR_WIDTH, DATA_WIDTH);

  state_e                r_state;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_port_from_mem;
  logic                  r_port_rvalid;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [ENTRY_W-1:0]    w_wentry;
  logic [ENTRY_W-1:0]    w_head;
  logic [ENTRY_W-1:0]    w_src;

  assign port_ready = !w_full;
  assign w_push     = port_valid && !w_full;
  assign w_pop      = (r_state == ST_REQ) && mem_gnt;
  assign w_wentry   = {port_write_rq, port_addr, port_to_mem};
  // An empty queue means the entry being pushed now becomes the head next cycle.
  assign w_src      = w_empty ? w_wentry : w_head;

  memport_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (w_wentry),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_port_from_mem <= '0;
      r_port_rvalid   <= 1'b0;
    end else begin
      r_port_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty || w_push) begin
            r_state     <= ST_REQ;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_src[ENTRY_W-1];
            r_mem_addr  <= w_src[ENTRY_W-2 -: ADDR_WIDTH];
            r_mem_wdata <= w_src[DATA_WIDTH-1:0];
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= r_mem_we ? ST_IDLE : ST_WAIT_R;
          end
        end
        ST_WAIT_R: begin
          if (mem_rvalid) begin
            r_port_from_mem <= mem_rdata;
            r_port_rvalid   <= 1'b1;
            r_state         <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign port_from_mem = r_port_from_mem;
  assign port_rvalid   = r_port_rvalid;

endmodule

// File: tb/tb_memory_port_bridge_32b.sv
// Scoreboard bench for memory_port_bridge_32b: directed requests push expected
// memory transactions and read returns; monitors pop and compare.
module tb_memory_port_bridge_32b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        port_valid;
  logic        port_ready;
  logic        port_write_rq;
  logic [31:0] port_addr;
  logic [31:0] port_to_mem;
  logic [31:0] port_from_mem;
  logic        port_rvalid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  memory_port_bridge_32b #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .port_valid    (port_valid),
    .port_ready    (port_ready),
    .port_write_rq (port_write_rq),
    .port_addr     (port_addr),
    .port_to_mem   (port_to_mem),
    .port_from_mem (port_from_mem),
    .port_rvalid   (port_rvalid),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } memtx_t;

  typedef struct {
    logic [31:0] data;
    int          acc;
    bit          chk_lat;
  } rdexp_t;

  memtx_t      exp_mem[$];
  rdexp_t      exp_rd[$];
  logic [31:0] rsp_q[$];

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  bit          gnt_en    = 1'b1;
  int          gnt_delay = 0;
  bit          rv_en     = 1'b1;
  bit          spur_rv   = 1'b0;
  logic [31:0] spur_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Backing-memory model: grants after gnt_delay waiting cycles, returns read
  // data the cycle after the grant.
  initial begin
    int          age;
    bit          rd_pend;
    logic [31:0] rsp;
    age = 0; rd_pend = 1'b0; rsp = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_rvalid = rd_pend || spur_rv;
      mem_rdata  = rd_pend ? rsp : spur_data;
      rd_pend    = 1'b0;
      mem_gnt    = gnt_en && mem_req && (age >= gnt_delay);
      @(negedge clk);
      if (!rst_n) begin
        age = 0; rd_pend = 1'b0;
      end else if (mem_req && mem_gnt) begin
        age = 0;
        if (!mem_we && rv_en) begin
          rd_pend = 1'b1;
          rsp = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'hBAD0BAD0;
        end
      end else if (mem_req) begin
        age++;
      end else begin
        age = 0;
      end
    end
  end

  // Monitor: grants, hold stability and read returns.
  initial begin
    bit          hold_pend;
    logic        h_we;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    memtx_t      e;
    rdexp_t      r;
    hold_pend = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
        continue;
      end
      if (mem_req && hold_pend) begin
        chk("hold_we",    32'(mem_we), 32'(h_we));
        chk("hold_addr",  mem_addr,    h_addr);
        chk("hold_wdata", mem_wdata,   h_wdata);
      end
      hold_pend = mem_req && !mem_gnt;
      h_we = mem_we; h_addr = mem_addr; h_wdata = mem_wdata;
      if (mem_req && mem_gnt) begin
        if (exp_mem.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_grant: got addr %h, required none", mem_addr);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_we",    32'(mem_we), 32'(e.we));
          chk("mem_addr",  mem_addr,    e.addr);
          chk("mem_wdata", mem_wdata,   e.data);
        end
      end
      if (port_rvalid) begin
        if (exp_rd.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rvalid: got data %h, required no pulse", port_from_mem);
        end else begin
          r = exp_rd.pop_front();
          chk("port_from_mem", port_from_mem, r.data);
          if (r.chk_lat) chk("read_latency", 32'(cyc - r.acc), 32'd3);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rdat, input bit lat);
    int     n;
    bit     done;
    memtx_t m;
    rdexp_t r;
    n = 0; done = 1'b0;
    @(posedge clk); #1;
    port_valid = 1'b1; port_write_rq = we; port_addr = a; port_to_mem = d;
    while (!done) begin
      @(negedge clk);
      if (port_ready) begin
        done = 1'b1;
        m.we = we; m.addr = a; m.data = d;
        exp_mem.push_back(m);
        if (!we) begin
          r.data = rdat; r.acc = cyc; r.chk_lat = lat;
          exp_rd.push_back(r);
          rsp_q.push_back(rdat);
        end
      end else if (++n > 200) begin
        done = 1'b1;
        tests++; fails++;
        $display("FAIL accept_timeout: got no port_ready for addr %h, required accept", a);
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    port_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_mem.size() != 0 || exp_rd.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_mem.size() != 0 || exp_rd.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got %0d/%0d pending, required 0/0", name,
               exp_mem.size(), exp_rd.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"},       32'(mem_req),     32'd0);
    chk({tag, "_mem_we"},        32'(mem_we),      32'd0);
    chk({tag, "_port_rvalid"},   32'(port_rvalid), 32'd0);
    chk({tag, "_port_from_mem"}, port_from_mem,    32'd0);
    chk({tag, "_mem_addr"},      mem_addr,         32'd0);
    chk({tag, "_mem_wdata"},     mem_wdata,        32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; port_valid = 1'b0; port_write_rq = 1'b0;
    port_addr = '0; port_to_mem = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(port_ready), 32'd1);

    // Single read with immediate grant, 3-cycle latency to port_rvalid.
    send(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    wait_idle("single_read");

    // Spurious mem_rvalid in IDLE.
    @(posedge clk); #1;
    spur_rv = 1'b1; spur_data = 32'h0000AAAA;
    @(posedge clk); #1;
    spur_rv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("spur_rvalid", 32'(port_rvalid), 32'd0);
    end
    chk("spur_hold_data", port_from_mem, 32'hDEADBEEF);

    // Write: exactly one grant with the request's fields, no read pulse.
    send(1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0);
    wait_idle("write");

    // Delayed grant: fields stable while mem_req waits.
    gnt_delay = 3;
    send(1'b1, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
    send(1'b0, 32'h44, 32'h0, 32'h0BADF00D, 1'b0);
    wait_idle("hold");
    gnt_delay = 0;
    chk("read_data_held", port_from_mem, 32'h0BADF00D);

    // Back-pressure: four accepts fill the queue, the fifth waits.
    gnt_en = 1'b0;
    send(1'b1, 32'h100, 32'h11111111, 32'h0, 1'b0);
    send(1'b0, 32'h104, 32'h0, 32'h22222222, 1'b0);
    send(1'b1, 32'h108, 32'h33333333, 32'h0, 1'b0);
    send(1'b0, 32'h10C, 32'h0, 32'h44444444, 1'b0);
    @(posedge clk); #1;
    port_valid = 1'b1; port_write_rq = 1'b1; port_addr = 32'h110; port_to_mem = 32'h55555555;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(port_ready), 32'd0);
    end
    @(posedge clk); #1;
    gnt_en = 1'b1;
    send(1'b1, 32'h110, 32'h55555555, 32'h0, 1'b0);
    wait_idle("backpressure");

    // Reset while a read is outstanding and a write is queued.
    rv_en = 1'b0;
    send(1'b0, 32'h200, 32'h0, 32'h77777777, 1'b0);
    n = 0;
    while (exp_mem.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_r_granted", 32'(exp_mem.size()), 32'd0);
    send(1'b1, 32'h204, 32'h99999999, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    exp_mem.delete(); exp_rd.delete(); rsp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; rv_en = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(port_ready), 32'd1);
    @(posedge clk); #1;
    spur_rv = 1'b1; spur_data = 32'h00005555;
    @(posedge clk); #1;
    spur_rv = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("late_rvalid", 32'(port_rvalid), 32'd0);
      chk("discard_req", 32'(mem_req),     32'd0);
    end
    chk("late_data", port_from_mem, 32'd0);
    chk("final_ready", 32'(port_ready), 32'd1);
    chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
